// File: rtl/access_lockout_if.sv
// Bundles the user-input side and the status outputs of access_lockout.
// The slave modport faces the controller; the master modport faces whatever
// drives the one-pulsed user inputs and observes the status outputs.
interface access_lockout_if #(
  parameter int DIGIT_W   = 4,
  parameter int KEY_LEN   = 4,
  parameter int MAX_TRIES = 3
);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  logic [DIGIT_W-1:0] pword;
  logic               pword_enter;
  logic               timeout;
  logic               logout;

  logic               enable;
  logic               reconf;
  logic               pass_red;
  logic               pass_green;
  logic               locked;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [IDX_W-1:0]   digit_idx;
  logic [2:0]         currentstate;

  modport master (
    output pword, pword_enter, timeout, logout,
    input  enable, reconf, pass_red, pass_green, locked,
           fail_cnt, digit_idx, currentstate
  );

  modport slave (
    input  pword, pword_enter, timeout, logout,
    output enable, reconf, pass_red, pass_green, locked,
           fail_cnt, digit_idx, currentstate
  );
endinterface

// File: rtl/access_lockout.sv
// Login controller: collects a KEY_LEN-digit code, compares it against KEY,
// then walks OK -> SET -> PLAY. Consecutive failed codes are counted and
// MAX_TRIES of them force a LOCK_CYCLES-long lockout. All outputs are Moore
// decodes of registered state.
module access_lockout #(
  parameter int DIGIT_W     = 4,
  parameter int KEY_LEN     = 4,
  parameter logic [KEY_LEN*DIGIT_W-1:0] KEY = 16'h3153,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 100
) (
  input  logic              CLK,
  input  logic              RST,
  access_lockout_if.slave   bus
);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int NSLOT  = 2 ** IDX_W;

  typedef enum logic [2:0] {
    ST_ENTRY  = 3'b001,
    ST_LOCKED = 3'b010,
    ST_OK     = 3'b101,
    ST_SET    = 3'b110,
    ST_PLAY   = 3'b111
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   digit_idx_q, digit_idx_d;
  logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic               miss_q, miss_d;

  // Key split into digits, digit 0 taken from the most-significant end.
  // Slots past KEY_LEN are unreachable and tied to zero so every index value
  // of digit_idx selects a defined entry.
  logic [DIGIT_W-1:0] key_digits [NSLOT];
  for (genvar g = 0; g < NSLOT; g++) begin : g_key
    if (g < KEY_LEN) begin : g_real
      assign key_digits[g] = KEY[(KEY_LEN-1-g)*DIGIT_W +: DIGIT_W];
    end else begin : g_pad
      assign key_digits[g] = '0;
    end
  end

  logic digit_miss;
  logic last_digit;
  assign digit_miss = (bus.pword != key_digits[digit_idx_q]);
  assign last_digit = (digit_idx_q == IDX_W'(KEY_LEN - 1));

  // Next-state and counter update; logout outranks timeout outranks pword_enter.
  always_comb begin
    // NOTE: every _d starts at its current value so no branch can infer a latch.
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    fail_cnt_d  = fail_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    miss_d      = miss_q;

    unique case (state_q)
      ST_ENTRY: begin
        if (bus.pword_enter) begin
          if (last_digit) begin
            digit_idx_d = '0;
            miss_d      = 1'b0;
            if (!(miss_q || digit_miss)) begin
              state_d    = ST_OK;
              fail_cnt_d = '0;
            end else begin
              fail_cnt_d = fail_cnt_q + FAIL_W'(1);
              if (fail_cnt_q == FAIL_W'(MAX_TRIES - 1)) begin
                state_d    = ST_LOCKED;
                lock_cnt_d = LOCK_W'(LOCK_CYCLES - 1);
              end
            end
          end else begin
            digit_idx_d = digit_idx_q + IDX_W'(1);
            miss_d      = miss_q | digit_miss;
          end
        end
      end

      ST_LOCKED: begin
        if (lock_cnt_q == '0) begin
          state_d    = ST_ENTRY;
          fail_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - LOCK_W'(1);
        end
      end

      ST_OK, ST_SET, ST_PLAY: begin
        if (bus.logout) begin
          state_d     = ST_ENTRY;
          digit_idx_d = '0;
          miss_d      = 1'b0;
        end else if (state_q == ST_PLAY) begin
          if (bus.timeout) state_d = ST_OK;
        end else if (bus.pword_enter) begin
          state_d = (state_q == ST_OK) ? ST_SET : ST_PLAY;
        end
      end

      default: begin
        state_d     = ST_ENTRY;
        digit_idx_d = '0;
        miss_d      = 1'b0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_ENTRY;
      digit_idx_q <= '0;
      fail_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      miss_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values together.
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      fail_cnt_q  <= fail_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      miss_q      <= miss_d;
    end
  end

  // Moore output decode of the registered state and counters.
  always_comb begin
    bus.enable       = (state_q == ST_PLAY);
    bus.reconf       = (state_q == ST_SET);
    bus.pass_red     = (state_q == ST_ENTRY) || (state_q == ST_LOCKED);
    bus.pass_green   = (state_q == ST_OK) || (state_q == ST_SET) || (state_q == ST_PLAY);
    bus.locked       = (state_q == ST_LOCKED);
    bus.fail_cnt     = fail_cnt_q;
    bus.digit_idx    = digit_idx_q;
    bus.currentstate = state_q;
  end
endmodule
